img_mem_arbiter: RTL and testbench
==================================

# img_mem_arbiter

Sequences the single shared image-memory interface between three requesters: camera capture (image write), SPI image readout (read) and image erase. Each operation runs to completion before the next starts. The block sits between the main control block and camera capture logic on one side and the memory interface block on the other. It turns level requests into one-cycle start pulses and returns per-requester done pulses.

## Interface
Parameters:
- IDX_W, 12, width of image index (matches main control block img_index)
- TIMEOUT_CYCLES, 24'd10_000_000, watchdog limit in sysClk cycles (used only with watchdog compiled in)

Ports (name, direction, width, meaning):
- sysClk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- cap_req  in  1  camera write request, level, held until cap_done
- cap_gnt  out  1  capture owns memory
- cap_done  out  1  one-cycle completion pulse
- rd_req  in  1  readout request, level
- rd_idx  in  IDX_W  image index to read
- rd_abort  in  1  stop-reading pulse from main control block
- rd_gnt  out  1  readout owns memory
- rd_done  out  1  one-cycle completion pulse
- er_req  in  1  erase request, level
- er_idx  in  IDX_W  image index to erase
- er_gnt  out  1  erase owns memory
- er_done  out  1  one-cycle completion pulse
- mem_op  out  2  00 none, 01 write, 10 read, 11 erase
- mem_idx  out  IDX_W  latched index for current op (0 for write)
- mem_start  out  1  one-cycle start pulse to memory interface
- mem_stop  out  1  one-cycle stop-reading pulse to memory interface
- mem_done  in  1  completion pulse from memory interface
- timeout  out  1  one-cycle watchdog-expiry pulse

## Operation
- States: IDLE, ISSUE, BUSY, RELEASE.
- Reset: state IDLE, all gnt/done/mem_start/mem_stop/timeout 0, mem_op 00, mem_idx 0, last_served = none.
- IDLE: with no request pending, stay in IDLE. Otherwise pick a winner. Base priority is cap > er > rd. The requester in last_served loses to any other pending requester, one-shot demotion, so no requester starves. Latch the winner, mem_op and index (rd_idx/er_idx sampled in this cycle), then go to ISSUE.
- ISSUE: mem_start = 1 for exactly one cycle; winner's gnt = 1. Go to BUSY.
- BUSY: gnt stays high; mem_op and mem_idx stay stable. When mem_done = 1, go to RELEASE.
- Request deassertion in BUSY is ignored; the op runs to completion.
- rd_abort while the read is granted (ISSUE or BUSY) produces a mem_stop pulse on the next cycle. The block still waits for mem_done. rd_abort at any other time is ignored.
- RELEASE: drop gnt; pulse the winner's done for one cycle; mem_op = 00; update last_served. Go to IDLE.
- mem_done outside BUSY is ignored. This includes mem_done in the same cycle as mem_start.
- Async rst mid-operation returns immediately to reset values. No done pulse is generated.

## Timing
- req sampled high in IDLE at cycle n → mem_start and gnt high at n+1.
- mem_done at cycle m (in BUSY) → gnt low and done high at m+1 → IDLE at m+2. The earliest next mem_start is m+3.
- Minimum op length is 4 cycles (IDLE, ISSUE, BUSY, RELEASE).
- All outputs are registered.

## Configuration
- IMG_ARB_WATCHDOG_EN defined:
  - A cycle counter clears on ISSUE and increments in BUSY.
  - When the counter reaches TIMEOUT_CYCLES with no mem_done, the block pulses timeout and goes to RELEASE. The done pulse is issued normally.
  - If mem_done arrives in the same cycle the counter reaches the limit, mem_done wins and there is no timeout pulse.
- IMG_ARB_WATCHDOG_EN undefined: BUSY waits indefinitely, timeout is tied to 0, and no counter is synthesised.

## Structure
- Shared package img_arb_pkg holds:
  - the state enum;
  - mem_op encodings OP_NONE/OP_WR/OP_RD/OP_ER;
  - requester id encoding (REQ_NONE/REQ_CAP/REQ_RD/REQ_ER).
- One sub-module, img_arb_watchdog: counter, clear/enable inputs and expiry output. It is instantiated only under IMG_ARB_WATCHDOG_EN.

## Test plan
- cap_req=1 and er_req=1 together from reset → cap granted first (mem_op=01). After cap's mem_done, er granted (mem_op=11, mem_idx=er_idx).
- rd_req with rd_idx=12'h0A5; mem_done 7 cycles after mem_start → rd_done at mem_done+1, mem_idx=0x0A5 throughout BUSY.
- cap_req held high continuously with rd_req pending → cap and rd alternate grants. rd is never skipped twice.
- rd granted, rd_abort pulse in BUSY → mem_stop one cycle later, gnt still high, rd_done after mem_done.
- rst asserted in BUSY → all outputs zero immediately, no done pulse, new req granted normally after rst release.
- With IMG_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16, no mem_done → timeout and er_done pulse 16 cycles into BUSY, then IDLE.

Source files
------------

// File: rtl/img_arb_pkg.sv
// img_arb_pkg: shared state, mem_op and requester encodings for img_mem_arbiter.
package img_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} arb_state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_CAP, REQ_RD, REQ_ER} req_id_t;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_ER   = 2'b11;
  function automatic logic [1:0] op_of(req_id_t id);
    return id == REQ_CAP ? OP_WR : id == REQ_RD ? OP_RD : id == REQ_ER ? OP_ER : OP_NONE;
  endfunction
endpackage

// File: rtl/img_arb_watchdog.sv
// img_arb_watchdog: BUSY-cycle counter that flags expiry on the cycle it reaches LIMIT.
module img_arb_watchdog #(
  parameter logic [23:0] LIMIT = 24'd10_000_000
) (
  input  logic sysClk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [23:0] cnt;
  always_ff @(posedge sysClk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 24'd1;
  assign expire = en && cnt == LIMIT - 24'd1;
endmodule

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: sequences capture/readout/erase over one memory port; watchdog under IMG_ARB_WATCHDOG_EN.
module img_mem_arbiter
  import img_arb_pkg::*;
#(
  parameter int          IDX_W          = 12,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic             sysClk,
  input  logic             rst,
  input  logic             cap_req,
  output logic             cap_gnt,
  output logic             cap_done,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_abort,
  output logic             rd_gnt,
  output logic             rd_done,
  input  logic             er_req,
  input  logic [IDX_W-1:0] er_idx,
  output logic             er_gnt,
  output logic             er_done,
  output logic [1:0]       mem_op,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_start,
  output logic             mem_stop,
  input  logic             mem_done,
  output logic             timeout
);
  arb_state_t state, state_n;
  req_id_t win, win_n, pick, last;
  logic cand_cap, cand_rd, cand_er, gnt_n, expire;
  logic [IDX_W-1:0] idx_n;
  always_comb begin
    cand_cap = cap_req && !(last == REQ_CAP && (er_req || rd_req));
    cand_er  = er_req && !(last == REQ_ER && (cap_req || rd_req));
    cand_rd  = rd_req && !(last == REQ_RD && (cap_req || er_req));
    pick     = cand_cap ? REQ_CAP : cand_er ? REQ_ER : cand_rd ? REQ_RD : REQ_NONE;
    win_n    = state == IDLE ? pick : win;
    state_n  = state;
    case (state)
      IDLE:    state_n = pick == REQ_NONE ? IDLE : ISSUE;
      ISSUE:   state_n = BUSY;
      BUSY:    state_n = (mem_done || expire) ? RELEASE : BUSY;
      default: state_n = IDLE;
    endcase
    gnt_n = state_n == ISSUE || state_n == BUSY;
    idx_n = state != IDLE ? mem_idx : pick == REQ_RD ? rd_idx : pick == REQ_ER ? er_idx : '0;
  end
  always_ff @(posedge sysClk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      win       <= REQ_NONE;
      last      <= REQ_NONE;
      mem_idx   <= '0;
      mem_op    <= OP_NONE;
      mem_start <= 1'b0;
      mem_stop  <= 1'b0;
      cap_gnt   <= 1'b0;
      rd_gnt    <= 1'b0;
      er_gnt    <= 1'b0;
      cap_done  <= 1'b0;
      rd_done   <= 1'b0;
      er_done   <= 1'b0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      last      <= state == RELEASE ? win : last;
      mem_idx   <= idx_n;
      mem_op    <= gnt_n ? op_of(win_n) : OP_NONE;
      mem_start <= state_n == ISSUE;
      mem_stop  <= rd_abort && win == REQ_RD && (state == ISSUE || state == BUSY);
      cap_gnt   <= gnt_n && win_n == REQ_CAP;
      rd_gnt    <= gnt_n && win_n == REQ_RD;
      er_gnt    <= gnt_n && win_n == REQ_ER;
      cap_done  <= state_n == RELEASE && win == REQ_CAP;
      rd_done   <= state_n == RELEASE && win == REQ_RD;
      er_done   <= state_n == RELEASE && win == REQ_ER;
    end
`ifdef IMG_ARB_WATCHDOG_EN
  img_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .sysClk(sysClk),
    .rst(rst),
    .clr(state == ISSUE),
    .en(state == BUSY),
    .expire(expire)
  );
  // a mem_done landing on the expiry cycle counts as a normal completion
  always_ff @(posedge sysClk or posedge rst)
    if (rst) timeout <= 1'b0;
    else timeout <= state == BUSY && expire && !mem_done;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_img_mem_arbiter.sv
// tb_img_mem_arbiter: directed checks of arbitration, timing, abort, reset and watchdog behaviour.
module tb_img_mem_arbiter;
  logic sysClk = 1'b0, rst = 1'b1;
  logic cap_req = 0, rd_req = 0, er_req = 0, rd_abort = 0, mem_done = 0;
  logic [11:0] rd_idx = '0, er_idx = '0;
  logic cap_gnt, cap_done, rd_gnt, rd_done, er_gnt, er_done, mem_start, mem_stop, timeout;
  logic [1:0] mem_op;
  logic [11:0] mem_idx;
  int errors = 0, checks = 0;
  localparam logic [8:0] F_CG = 9'h100, F_RG = 9'h080, F_EG = 9'h040, F_CD = 9'h020,
                         F_RD = 9'h010, F_ED = 9'h008, F_ST = 9'h004, F_SP = 9'h002, F_TO = 9'h001;
  wire [8:0] flags = {cap_gnt, rd_gnt, er_gnt, cap_done, rd_done, er_done, mem_start, mem_stop, timeout};
  img_mem_arbiter #(.IDX_W(12), .TIMEOUT_CYCLES(24'd16)) dut (
    .sysClk(sysClk), .rst(rst),
    .cap_req(cap_req), .cap_gnt(cap_gnt), .cap_done(cap_done),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_abort(rd_abort), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .er_req(er_req), .er_idx(er_idx), .er_gnt(er_gnt), .er_done(er_done),
    .mem_op(mem_op), .mem_idx(mem_idx), .mem_start(mem_start), .mem_stop(mem_stop),
    .mem_done(mem_done), .timeout(timeout)
  );
  always #5 sysClk = ~sysClk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [8:0] f, input logic [1:0] op);
    check({tag, ".flags"}, 32'(flags), 32'(f));
    check({tag, ".op"}, 32'(mem_op), 32'(op));
  endtask
  task automatic step();
    @(posedge sysClk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge sysClk);
    #1 rst = 1'b0;
    expect_out("reset", 9'h0, 2'b00);
    check("reset.idx", 32'(mem_idx), 32'h0);
    // cap and er together: cap first, then er with its index
    cap_req = 1; er_req = 1; er_idx = 12'h3C1;
    step(); expect_out("t1.cap_issue", F_CG | F_ST, 2'b01);
    check("t1.cap_idx", 32'(mem_idx), 32'h0);
    step(); expect_out("t1.cap_busy", F_CG, 2'b01);
    mem_done = 1;
    step(); expect_out("t1.cap_rel", F_CD, 2'b00);
    mem_done = 0; cap_req = 0;
    step(); expect_out("t1.idle", 9'h0, 2'b00);
    step(); expect_out("t1.er_issue", F_EG | F_ST, 2'b11);
    check("t1.er_idx", 32'(mem_idx), 32'h3C1);
    step(); expect_out("t1.er_busy", F_EG, 2'b11);
    mem_done = 1;
    step(); expect_out("t1.er_rel", F_ED, 2'b00);
    mem_done = 0; er_req = 0;
    step(); expect_out("t1.idle2", 9'h0, 2'b00);
    // read with latched index, mem_done in ISSUE ignored, real done 7 cycles after start
    rd_req = 1; rd_idx = 12'h0A5;
    step(); expect_out("t2.issue", F_RG | F_ST, 2'b10);
    rd_idx = 12'h111; mem_done = 1;
    for (int i = 1; i <= 7; i++) begin
      step(); mem_done = 0;
      expect_out($sformatf("t2.busy%0d", i), F_RG, 2'b10);
      check($sformatf("t2.idx%0d", i), 32'(mem_idx), 32'h0A5);
      if (i == 7) mem_done = 1;
    end
    step(); expect_out("t2.rel", F_RD, 2'b00);
    mem_done = 0; rd_req = 0;
    step(); expect_out("t2.idle", 9'h0, 2'b00);
    // cap held with rd pending: grants alternate
    cap_req = 1; rd_req = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k % 2 == 0) expect_out($sformatf("t3.issue%0d", k), F_CG | F_ST, 2'b01);
      else expect_out($sformatf("t3.issue%0d", k), F_RG | F_ST, 2'b10);
      step(); mem_done = 1;
      step(); expect_out($sformatf("t3.rel%0d", k), k % 2 == 0 ? F_CD : F_RD, 2'b00);
      mem_done = 0;
      if (k == 3) begin cap_req = 0; rd_req = 0; end
      step();
    end
    expect_out("t3.idle", 9'h0, 2'b00);
    // rd_abort in BUSY gives one mem_stop, grant held until mem_done
    rd_req = 1;
    step(); expect_out("t4.issue", F_RG | F_ST, 2'b10);
    step(); rd_abort = 1;
    step(); rd_abort = 0;
    expect_out("t4.stop", F_RG | F_SP, 2'b10);
    step(); expect_out("t4.after_stop", F_RG, 2'b10);
    mem_done = 1;
    step(); expect_out("t4.rel", F_RD, 2'b00);
    mem_done = 0; rd_req = 0;
    step(); rd_abort = 1;
    step(); rd_abort = 0;
    expect_out("t4.idle_abort", 9'h0, 2'b00);
    // async reset in BUSY
    er_req = 1; er_idx = 12'h7FF;
    step(); expect_out("t5.issue", F_EG | F_ST, 2'b11);
    step(); expect_out("t5.busy", F_EG, 2'b11);
    #2 rst = 1;
    #1 expect_out("t5.rst_now", 9'h0, 2'b00);
    check("t5.rst_idx", 32'(mem_idx), 32'h0);
    er_req = 0;
    step(); step(); expect_out("t5.rst_hold", 9'h0, 2'b00);
    rst = 0;
    step(); expect_out("t5.post_rst", 9'h0, 2'b00);
    cap_req = 1;
    step(); expect_out("t5.cap_issue", F_CG | F_ST, 2'b01);
    step(); mem_done = 1;
    step(); expect_out("t5.cap_rel", F_CD, 2'b00);
    mem_done = 0; cap_req = 0;
    step();
    // no mem_done: watchdog expires after 16 BUSY cycles, otherwise BUSY persists
    er_req = 1; er_idx = 12'h042;
    step(); expect_out("t6.issue", F_EG | F_ST, 2'b11);
    for (int i = 1; i <= 16; i++) begin
      step(); expect_out($sformatf("t6.busy%0d", i), F_EG, 2'b11);
    end
    step();
`ifdef IMG_ARB_WATCHDOG_EN
    expect_out("t6.timeout", F_ED | F_TO, 2'b00);
`else
    expect_out("t6.no_timeout", F_EG, 2'b11);
    mem_done = 1;
    step(); expect_out("t6.rel", F_ED, 2'b00);
    mem_done = 0;
`endif
    er_req = 0;
    step(); expect_out("t6.idle", 9'h0, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
